// File: rtl/mem_responder.sv
// Memory-side responder for the CPU serial bus: decodes TX messages into
// synchronous 16-bit memory accesses and streams read data back as RX replies.
module mem_responder #(
  parameter int unsigned NSHIFT     = 2,
  parameter int unsigned READ_DELAY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSHIFT-1:0] rx_in_pins,
  output logic [NSHIFT-1:0] tx_out_pins,
  output logic [14:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_wmask,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              error
);

  localparam int unsigned W  = 16 / NSHIFT;
  localparam int unsigned WB = (W / 2 == 0) ? 1 : W / 2;
  localparam int unsigned CW = 5;
  localparam int unsigned DW = 16;

  localparam logic [1:0] CMD_RD   = 2'd0;
  localparam logic [1:0] CMD_WR8  = 2'd1;
  localparam logic [1:0] CMD_WR16 = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_EXEC} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [14:0]       mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_wmask_q, mem_wmask_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic              rd_pend_q, rd_pend_d;
  logic              buf_full_q, buf_full_d;
  logic [15:0]       buf_q, buf_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [NSHIFT-1:0] tx_out_q, tx_out_d;
  logic [15:0]       tx_sh_q, tx_sh_d;
  logic [CW-1:0]     tx_rem_q, tx_rem_d;
  logic              tx_on_q, tx_on_d;

  logic [15:0]   addr_full;
  logic [15:0]   data_full;
  logic [CW-1:0] data_last;
  logic          load;
  logic          tx_start;
  logic [15:0]   tx_src;

  // Registers for receiver, reply buffer and transmitter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_q       <= '0;
      dly_q       <= '0;
      tx_out_q    <= '0;
      tx_sh_q     <= '0;
      tx_rem_q    <= '0;
      tx_on_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      rd_pend_q   <= rd_pend_d;
      buf_full_q  <= buf_full_d;
      buf_q       <= buf_d;
      dly_q       <= dly_d;
      tx_out_q    <= tx_out_d;
      tx_sh_q     <= tx_sh_d;
      tx_rem_q    <= tx_rem_d;
      tx_on_q     <= tx_on_d;
    end
  end

  // Next-state logic; strobes and pins are computed one cycle ahead so they register out on time
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    error_d     = error_q;
    rd_pend_d   = mem_re_q;
    buf_full_d  = buf_full_q;
    buf_d       = buf_q;
    dly_d       = dly_q;
    tx_out_d    = '0;
    tx_sh_d     = tx_sh_q;
    tx_rem_d    = tx_rem_q;

    addr_full = (addr_q >> NSHIFT) | (16'(rx_in_pins) << (16 - NSHIFT));
    data_full = (data_q >> NSHIFT) | (16'(rx_in_pins) << (16 - NSHIFT));
    data_last = (cmd_q == CMD_WR8) ? CW'(WB - 1) : CW'(W - 1);

    unique case (state_q)
      S_IDLE: if (rx_in_pins[0]) state_d = S_CMD;
      S_CMD: begin
        cmd_d   = rx_in_pins[1:0];
        cnt_d   = '0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        addr_d = addr_full;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          cnt_d = '0;
          case (cmd_q)
            CMD_RD: begin
              state_d    = S_EXEC;
              mem_re_d   = 1'b1;
              mem_addr_d = addr_full[15:1];
            end
            CMD_WR8, CMD_WR16: state_d = S_DATA;
            default: begin
              error_d = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_DATA: begin
        data_d = data_full;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == data_last) begin
          state_d    = S_EXEC;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q[15:1];
          if (cmd_q == CMD_WR16) begin
            mem_wdata_d = data_full;
            mem_wmask_d = 2'b11;
          end else begin
            // Byte payload lands in the top byte after the shorter shift
            mem_wdata_d = {data_full[15:8], data_full[15:8]};
            mem_wmask_d = addr_q[0] ? 2'b10 : 2'b01;
          end
        end
      end
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Reply buffer: zero-delay replies bypass the buffer straight into the transmitter
    load     = rd_pend_q;
    tx_start = (tx_rem_q == '0) &&
               ((buf_full_q && (dly_q <= DW'(1))) ||
                (!buf_full_q && load && (READ_DELAY == 0)));
    tx_src   = buf_full_q ? buf_q : mem_rdata;

    if (buf_full_q && (dly_q != '0)) dly_d = dly_q - DW'(1);
    if (tx_start) buf_full_d = 1'b0;
    if (load) begin
      if (buf_full_q && !tx_start) begin
        error_d = 1'b1;
      end else if (buf_full_q || !tx_start) begin
        buf_full_d = 1'b1;
        buf_d      = mem_rdata;
        dly_d      = DW'(READ_DELAY);
      end
    end

    if (tx_start) begin
      tx_out_d = NSHIFT'(1);
      tx_sh_d  = tx_src;
      tx_rem_d = CW'(W);
    end else if (tx_rem_q != '0) begin
      tx_out_d = tx_sh_q[NSHIFT-1:0];
      tx_sh_d  = tx_sh_q >> NSHIFT;
      tx_rem_d = tx_rem_q - CW'(1);
    end
    tx_on_d = tx_start || (tx_rem_q != '0);

    busy_d = (state_d != S_IDLE) || buf_full_d || tx_on_d || rd_pend_d;
  end

  assign tx_out_pins = tx_out_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign busy        = busy_q;
  assign error       = error_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side end of the CPU's serial bus. Receives TX messages from the CPU on `rx_in_pins`, NSHIFT bits per cycle: a start cycle, a command cycle, a 16-bit address, and for writes the payload. Executes each message against a synchronous 16-bit memory port. For reads, it returns the data as an RX message on `tx_out_pins`. Serves as the bus model in simulation and as the interface block for on-board RAM.

## Interface
- `NSHIFT`, 2, bits transferred per cycle in each direction; must divide 16.
- `READ_DELAY`, 0, extra idle cycles inserted between read-data capture and reply start.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_in_pins`  in  NSHIFT  incoming message pins; all zero when idle.
- `tx_out_pins`  out  NSHIFT  reply pins; all zero when idle.
- `mem_addr`  out  15  word address (byte address bits [15:1]).
- `mem_wdata`  out  16  write data, little-endian.
- `mem_wmask`  out  2  byte enables; bit 0 is the low byte.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe.
- `mem_rdata`  in  16  read data, valid the cycle after `mem_re`.
- `busy`  out  1  receiver not in IDLE, or reply buffer full, or reply in flight.
- `error`  out  1  sticky protocol error; cleared only by reset.

## Operation
- All fields are shifted LSB first. Cycle k of a field carries bits [k*NSHIFT +: NSHIFT]. Define W = 16/NSHIFT.
- Receiver FSM states: IDLE, CMD, ADDR, DATA, EXEC.
  - IDLE → CMD when `rx_in_pins[0]` = 1 (start cycle). Other pin bits in the start cycle are ignored.
  - CMD: latch `rx_in_pins[1:0]`. 0 = READ_16, 1 = WRITE_8, 2 = WRITE_16, 3 = reserved. Go to ADDR.
  - ADDR: W cycles into the address shift register. After the last cycle:
    - READ_16 → EXEC.
    - WRITE_16 → DATA with W cycles.
    - WRITE_8 → DATA with W/2 cycles.
    - Reserved → set `error`, return to IDLE, issue no memory access.
  - DATA: shift payload into `mem_wdata` staging, then → EXEC.
  - EXEC (one cycle), then → IDLE:
    - READ_16: `mem_re`=1, `mem_addr`=addr[15:1].
    - WRITE_16: `mem_we`=1, `mem_wmask`=2'b11, `mem_wdata`=payload.
    - WRITE_8: `mem_we`=1, `mem_wmask`=addr[0] ? 2'b10 : 2'b01, payload byte placed on both halves of `mem_wdata`.
- Word operations ignore addr[0]. Writes produce no reply.
- Reply path, decoupled from the receiver:
  - A one-entry reply buffer loads `mem_rdata` in the cycle after the READ_16 EXEC.
  - A delay counter then counts READ_DELAY cycles.
  - The transmitter then drives one start cycle (`tx_out_pins` = 1), followed by W data cycles from the buffer.
  - The buffer frees at the transmitter's start cycle.
- Read data arriving while the buffer is still full: set `error`, drop the new data, keep the old data.
- The receiver keeps accepting messages while a reply is being sent. The two directions are full duplex.

## Timing
- Reset: FSM in IDLE, buffer empty, transmitter idle. All outputs 0: `tx_out_pins`, `mem_*` strobes, `mem_addr`, `mem_wdata`, `mem_wmask`, `busy`, `error`.
- Reset asserted mid-message or mid-reply aborts everything immediately. Pins are 0 the next cycle, and no strobe is issued.
- Message start in cycle T (NSHIFT=2, W=8). CMD at T+1, ADDR at T+2..T+9.
- READ_16:
  - `mem_re` at T+10; buffer loaded at end of T+11.
  - Reply start cycle at T+12+READ_DELAY; data at T+13+READ_DELAY..T+20+READ_DELAY.
- WRITE_16: DATA at T+10..T+17, `mem_we` at T+18.
- WRITE_8: DATA at T+10..T+13, `mem_we` at T+14.
- The receiver is back in IDLE the cycle after EXEC. A new start bit may arrive the cycle after EXEC; the start cycle is never accepted during EXEC.
- `mem_we` and `mem_re` are never high in the same cycle, and each is exactly one cycle wide.
- `busy` is registered and reflects state at the cycle boundary.

## Test plan
- READ_16 at 0x1234, memory holds 0xBEEF at word 0x091A:
  - Expect `mem_re` at T+10 with `mem_addr`=0x091A.
  - Expect `tx_out_pins` = 1 at T+12, then 3,3,2,3,2,3,3,2 (0xBEEF LSB first) at T+13..T+20, then 0.
- WRITE_16 at 0x0040, payload 0xA55A: expect `mem_we` at T+18 with `mem_addr`=0x0020, `mem_wmask`=11, `mem_wdata`=0xA55A. No reply.
- WRITE_8 at 0x0041, byte 0x7E: expect `mem_we` at T+14 with `mem_wmask`=10, `mem_wdata`=0x7E7E.
- Two READ_16 messages back to back (second start at T+11), READ_DELAY=0:
  - Expect two complete replies with no overlap.
  - Expect `error` stays 0.
- READ_DELAY=12 and two back-to-back reads: expect `error`=1, first reply data intact, second read's data dropped.
- Reserved command 3: expect `error`=1 at T+10, no `mem_we`/`mem_re`, a following READ_16 is served normally.
- Reset asserted at T+5 of a WRITE_16:
  - Expect no `mem_we`, all outputs 0.
  - A fresh WRITE_16 after reset completes on schedule.
